// File: rtl/rtype_exec.sv
// rtype_exec: R-type sequencer and sole writer of the 32x32 GPR file.
// Sequence: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Optional macro RTYPE_EXEC_MULT_EN: adds legal MULT (funct 0x18),
// a 32-cycle shift-add multiply in EXEC.
// Ports:
//   clk, rst           clock, sync active-high reset
//   instr_valid/ready  instruction handshake, instr = R-type word
//   gpr_addr_a/b       read addresses (latched rs/rt)
//   gpr_a/b            combinational read data
//   gpr_we/addr_c/c    single-cycle write-back port
//   done, illegal      WB pulse, illegal qualifies done
module rtype_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  gpr_addr_a,
  output logic [4:0]  gpr_addr_b,
  input  logic [31:0] gpr_a,
  input  logic [31:0] gpr_b,
  output logic        gpr_we,
  output logic [4:0]  gpr_addr_c,
  output logic [31:0] gpr_c,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
`ifdef RTYPE_EXEC_MULT_EN
  localparam logic [5:0] F_MULT = 6'h18;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  op_q;
  logic [5:0]  funct_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [4:0]  sh_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        legal;
  logic [31:0] alu;
  logic        exec_done;

`ifdef RTYPE_EXEC_MULT_EN
  logic [4:0]  cnt_q;
  logic        is_mult;

  assign is_mult   = (op_q == 6'd0) && (funct_q == F_MULT);
  assign exec_done = !is_mult || (cnt_q == 5'd31);
`else
  assign exec_done = 1'b1;
`endif

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_WB);
  assign illegal     = done && !legal;
  assign gpr_we      = done && legal && (rd_q != 5'd0) && !rst;
  assign gpr_addr_a  = rs_q;
  assign gpr_addr_b  = rt_q;
  assign gpr_addr_c  = rd_q;
  assign gpr_c       = res_q;

  always_comb begin
    legal = (op_q == 6'd0);
    alu   = '0;
    case (funct_q)
      F_ADD:  alu = a_q + b_q;
      F_SUB:  alu = a_q - b_q;
      F_AND:  alu = a_q & b_q;
      F_OR:   alu = a_q | b_q;
      F_XOR:  alu = a_q ^ b_q;
      F_NOR:  alu = ~(a_q | b_q);
      F_SLT:  alu = {31'd0, $signed(a_q) < $signed(b_q)};
      F_SLTU: alu = {31'd0, a_q < b_q};
      F_SLL:  alu = b_q << sh_q;
      F_SRL:  alu = b_q >> sh_q;
      F_SRA:  alu = $unsigned($signed(b_q) >>> sh_q);
`ifdef RTYPE_EXEC_MULT_EN
      F_MULT: alu = '0;
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (instr_valid) state_nxt = S_READ;
      S_READ: state_nxt = S_EXEC;
      S_EXEC: if (exec_done) state_nxt = S_WB;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      funct_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      sh_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef RTYPE_EXEC_MULT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr[31:26];
            rs_q    <= instr[25:21];
            rt_q    <= instr[20:16];
            rd_q    <= instr[15:11];
            sh_q    <= instr[10:6];
            funct_q <= instr[5:0];
          end
        end
        S_READ: begin
          a_q   <= gpr_a;
          b_q   <= gpr_b;
          // res_q doubles as the multiply accumulator
          res_q <= '0;
`ifdef RTYPE_EXEC_MULT_EN
          cnt_q <= '0;
`endif
        end
        S_EXEC: begin
`ifdef RTYPE_EXEC_MULT_EN
          if (is_mult) begin
            // a_q shifts up as multiplicand, b_q down as multiplier
            res_q <= res_q + (b_q[0] ? a_q : 32'd0);
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 5'd1;
          end else begin
            res_q <= alu;
          end
`else
          res_q <= alu;
`endif
        end
        S_WB: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec.sv
// tb_rtype_exec: scoreboard bench for rtype_exec with a GPR file model.
// Directed test-plan cases followed by randomized R-type words.
module tb_rtype_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  gpr_addr_a;
  logic [4:0]  gpr_addr_b;
  logic [31:0] gpr_a;
  logic [31:0] gpr_b;
  logic        gpr_we;
  logic [4:0]  gpr_addr_c;
  logic [31:0] gpr_c;
  logic        done;
  logic        illegal;

  always #5 clk = ~clk;

  rtype_exec dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .gpr_addr_a  (gpr_addr_a),
    .gpr_addr_b  (gpr_addr_b),
    .gpr_a       (gpr_a),
    .gpr_b       (gpr_b),
    .gpr_we      (gpr_we),
    .gpr_addr_c  (gpr_addr_c),
    .gpr_c       (gpr_c),
    .done        (done),
    .illegal     (illegal)
  );

  logic [31:0] rf     [32];
  logic [31:0] rf_ref [32];
  logic        preload;

  assign gpr_a = rf[gpr_addr_a];
  assign gpr_b = rf[gpr_addr_b];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_ref[i];
    end else if (gpr_we === 1'b1) begin
      rf[gpr_addr_c] <= gpr_c;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ill;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] val;
    int          cyc0;
    int          lat;
  } exp_t;

  exp_t sbq [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] rd,
                                      input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  // Reference: architectural effect of one instruction on rf_ref.
  function automatic void model(input logic [31:0] w, output logic leg,
                                output logic [31:0] r, output int lat);
    logic [31:0]     a;
    logic [31:0]     b;
    int unsigned     sh;
    logic [63:0]     p;
    a   = rf_ref[w[25:21]];
    b   = rf_ref[w[20:16]];
    sh  = w[10:6];
    leg = (w[31:26] == 6'd0);
    r   = 32'd0;
    lat = 3;
    p   = 64'd0;
    case (w[5:0])
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      6'h03: r = int'(b) >>> sh;
      6'h18: begin
`ifdef RTYPE_EXEC_MULT_EN
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        if (leg) lat = 34;
`else
        leg = 1'b0;
`endif
      end
      default: leg = 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [31:0] w, input bit track,
                       input bit hold);
    exp_t        e;
    logic        leg;
    logic [31:0] r;
    int          lat;
    model(w, leg, r, lat);
    instr_valid = 1'b1;
    instr       = w;
    if (track) begin
      e.ill  = !leg;
      e.we   = leg && (w[15:11] != 5'd0);
      e.rd   = w[15:11];
      e.val  = r;
      e.cyc0 = cyc;
      e.lat  = lat;
      sbq.push_back(e);
      if (e.we) rf_ref[e.rd] = r;
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (instr_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic run(input logic [31:0] w);
    wait_ready();
    issue(w, 1'b1, 1'b0);
    wait_ready();
  endtask

  exp_t mon_e;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst !== 1'b1 &&
        (done === 1'b1 || gpr_we === 1'b1 || illegal === 1'b1)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_wb actual=done%b/we%b expected=idle",
                 done, gpr_we);
      end else begin
        mon_e = sbq.pop_front();
        chk("done", {31'd0, done}, 32'd1);
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
        chk("gpr_we", {31'd0, gpr_we}, {31'd0, mon_e.we});
        if (mon_e.we) begin
          chk("addr_c", {27'd0, gpr_addr_c}, {27'd0, mon_e.rd});
          chk("gpr_c", gpr_c, mon_e.val);
        end
        chk("latency", cyc - mon_e.cyc0, mon_e.lat);
        chk("done_gap", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_done = (done === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [5:0]  ftab [12];
  logic [31:0] w;
  logic [31:0] keep7;
  logic [31:0] keep13;
  logic [5:0]  fn;
  int          idx;

  initial begin
    ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h18};
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    preload     = 1'b1;
    for (int i = 0; i < 32; i++) rf_ref[i] = (i == 0) ? 32'd0 : $urandom;
    rf_ref[2] = 32'h00055500;
    rf_ref[6] = 32'h0003C000;
    keep7  = rf_ref[7];
    keep13 = rf_ref[13];
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rst     = 1'b0;

    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, gpr_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_addr_a", {27'd0, gpr_addr_a}, 32'd0);
    chk("rst_addr_b", {27'd0, gpr_addr_b}, 32'd0);
    chk("rst_addr_c", {27'd0, gpr_addr_c}, 32'd0);
    chk("rst_gpr_c", gpr_c, 32'd0);
    @(posedge clk);
    #1;

    // ADD r9,r2,r6 with cycle-exact checks
    wait_ready();
    issue(32'h00464820, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_addr_a", {27'd0, gpr_addr_a}, 32'd2);
    chk("t1_addr_b", {27'd0, gpr_addr_b}, 32'd6);
    chk("t1_busy", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_we", {31'd0, gpr_we}, 32'd1);
    chk("t1_addr_c", {27'd0, gpr_addr_c}, 32'd9);
    chk("t1_gpr_c", gpr_c, 32'h00091500);
    chk("t1_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("t1_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;

    run(enc(5'd6, 5'd2, 5'd10, 5'd0, 6'h22));
    chk("t2_sub", rf[10], 32'hFFFE6B00);
    run(enc(5'd10, 5'd2, 5'd11, 5'd0, 6'h2A));
    chk("t2_slt", rf[11], 32'd1);
    run(enc(5'd10, 5'd2, 5'd11, 5'd0, 6'h2B));
    chk("t2_sltu", rf[11], 32'd0);
    run(enc(5'd0, 5'd10, 5'd12, 5'd4, 6'h03));
    chk("t2_sra", rf[12], 32'hFFFFE6B0);
    run(enc(5'd0, 5'd10, 5'd12, 5'd4, 6'h02));
    chk("t2_srl", rf[12], 32'h0FFFE6B0);

    run(enc(5'd2, 5'd6, 5'd0, 5'd0, 6'h20));
    chk("t3_r0", rf[0], 32'd0);
    w = enc(5'd2, 5'd6, 5'd7, 5'd0, 6'h20);
    w[31:26] = 6'h08;
    run(w);
    chk("t3_r7", rf[7], keep7);

    // reset during WB of ADD r9 must suppress the write
    run(enc(5'd6, 5'd2, 5'd9, 5'd0, 6'h22));
    chk("t4_pre", rf[9], 32'hFFFE6B00);
    wait_ready();
    issue(32'h00464820, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_we_gated", {31'd0, gpr_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ready", {31'd0, instr_ready}, 32'd1);
    chk("t4_we", {31'd0, gpr_we}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_illegal", {31'd0, illegal}, 32'd0);
    chk("t4_addr_a", {27'd0, gpr_addr_a}, 32'd0);
    chk("t4_addr_b", {27'd0, gpr_addr_b}, 32'd0);
    chk("t4_addr_c", {27'd0, gpr_addr_c}, 32'd0);
    chk("t4_gpr_c", gpr_c, 32'd0);
    chk("t4_r9", rf[9], 32'hFFFE6B00);
    @(posedge clk);
    #1;

    // valid held with changing words while busy
    wait_ready();
    issue(enc(5'd2, 5'd6, 5'd14, 5'd0, 6'h20), 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      instr = enc(5'($urandom), 5'($urandom), 5'd15, 5'd0, 6'h25);
      @(negedge clk);
      chk("t5_busy", {31'd0, instr_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t5_ready4", {31'd0, instr_ready}, 32'd1);
    issue(enc(5'd14, 5'd2, 5'd16, 5'd0, 6'h20), 1'b1, 1'b0);
    wait_ready();
    chk("t5_r16", rf[16], 32'h000E6A00);

    run(enc(5'd2, 5'd6, 5'd13, 5'd0, 6'h18));
`ifdef RTYPE_EXEC_MULT_EN
    chk("t6_mult", rf[13], 32'hFEC00000);
`else
    chk("t6_nowrite", rf[13], keep13);
`endif

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 12);
      fn  = (idx == 12) ? 6'($urandom) : ftab[idx];
      w   = enc(5'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), fn);
      if ($urandom_range(0, 7) == 0) w[31:26] = 6'($urandom_range(1, 63));
      run(w);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf_final_%0d", i), rf[i], rf_ref[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtype_exec.md
# rtype_exec

Sequencer that sits directly upstream of the 32x32 general-purpose register file and is its only writer. It accepts one MIPS-style R-type instruction word at a time through a valid/ready handshake. It drives the register file's two read addresses and captures the read operands, executes the ALU operation, and issues a single-cycle write-back on the file's write port. Throughput is one instruction per 4 cycles, or 35 cycles for multiply when configured.

## Interface
Parameters: none.

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word presented
- instr_ready  out  1  block can accept an instruction (high only in IDLE)
- instr  in  32  op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- gpr_addr_a  out  5  register-file read address A (= latched rs)
- gpr_addr_b  out  5  register-file read address B (= latched rt)
- gpr_a  in  32  register-file read data A (combinational read)
- gpr_b  in  32  register-file read data B (combinational read)
- gpr_we  out  1  register-file write enable
- gpr_addr_c  out  5  register-file write address (= latched rd)
- gpr_c  out  32  register-file write data
- done  out  1  one-cycle pulse in the WB cycle
- illegal  out  1  qualifies `done`: instruction was rejected, no write

Clock and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- **State machine:** IDLE -> READ -> EXEC -> WB -> IDLE.
- **Accept:** in IDLE, `instr_valid && instr_ready` latches `instr`, and the state goes to READ.
- **READ:** `gpr_addr_a/b` come from the latched rs/rt. At the end of READ, `gpr_a/b` are registered into the operand registers.
- **EXEC:** the result register is loaded and the state goes to WB. MULT under the macro is the exception (see Configuration).
- **WB:** `done` pulses. `gpr_we` is asserted when the instruction is legal, rd != 0, and `rst` is low.
- **Address and data stability:** `gpr_addr_c` and `gpr_c` are driven from registers and stay stable whenever `gpr_we` is high.
- **Supported funct codes:**
  - ADD 0x20 and SUB 0x22: modulo 2^32, no overflow trap.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A (signed) and SLTU 0x2B (unsigned): result is 0 or 1.
  - SLL 0x00, SRL 0x02, SRA 0x03: operand is rt, shift amount is shamt.
- **Illegal instruction:** op != 0, or a funct not listed above. The instruction still runs the full 4-cycle sequence; in WB, `done` = 1, `illegal` = 1, and `gpr_we` = 0.
- **Writes to r0:** rd = 0 with a legal op gives `done` = 1, `illegal` = 0, `gpr_we` = 0.
- **Input while busy:** `instr_valid` outside IDLE is ignored, and the held `instr` is not sampled.

## Timing
- **Reset values:** state IDLE, `instr_ready` = 1, all other outputs 0, all internal registers 0.
- **Cycle numbering:** cycle 0 is the handshake cycle.
  - Cycle 1 is READ; operands are captured at its closing edge.
  - Cycle 2 is EXEC.
  - Cycle 3 is WB; the register file is written at its closing edge.
  - Cycle 4 is IDLE with `instr_ready` = 1.
- **Back-to-back instructions:** minimum spacing between acceptances is 4 cycles.
- **No read-after-write hazard:** a following instruction's READ happens no earlier than the cycle after the previous write edge.
- **Reset mid-operation:** `rst` high in any cycle aborts the sequence with no write. `gpr_we` is gated by `!rst` even in WB. The state is IDLE the next cycle.
- **`done`/`illegal`:** both are high only in WB and are never high in consecutive cycles.

## Configuration
- **Macro:** `RTYPE_EXEC_MULT_EN`.
- **Defined:** funct 0x18 (MULT) is legal.
  - EXEC runs a 32-iteration shift-add multiply, one iteration per cycle, with a 5-bit iteration counter. EXEC occupies cycles 2..33 and WB is cycle 34.
  - The low 32 bits of the unsigned product go to rd.
  - `rst` during the iterations aborts with no write.
- **Undefined:** funct 0x18 is illegal, and no multiplier logic or counter is synthesised.

## Test plan
The bench's register-file model is preloaded with r2 = 0x00055500 and r6 = 0x0003C000.

1. ADD r9,r2,r6, `instr` = 0x00464820, accepted in cycle 0 -> `gpr_addr_a` = 2 and `gpr_addr_b` = 6 in cycle 1; in cycle 3, `gpr_we` = 1, `gpr_addr_c` = 9, `gpr_c` = 0x00091500, `done` = 1; `instr_ready` = 1 in cycle 4.
2. SUB r10,r6,r2 -> r10 = 0xFFFE6B00. Then:
   - SLT r11,r10,r2 -> r11 = 1.
   - SLTU r11,r10,r2 -> r11 = 0.
   - SRA r12,r10,4 -> r12 = 0xFFFFE6B0.
   - SRL r12,r10,4 -> r12 = 0x0FFFE6B0.
3. ADD with rd = 0, and separately an instruction with op = 0x08 -> `done` = 1 in WB with `gpr_we` = 0; `illegal` = 0 for the first, `illegal` = 1 for the second; the register file is unchanged.
4. `rst` raised in the WB cycle of ADD r9,r2,r6 -> `gpr_we` = 0, r9 retains its old value, the next cycle is IDLE with `instr_ready` = 1 and all other outputs 0.
5. `instr_valid` held high with changing `instr` across cycles 1-3 -> only the cycle-0 word executes, and the next acceptance is in cycle 4.
6. MULT r13,r2,r6:
   - With `RTYPE_EXEC_MULT_EN` -> `gpr_we` = 1 in cycle 34 with `gpr_c` = 0xFEC00000.
   - Without it -> `illegal` = 1 in cycle 3 and no write.
